// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_gen
// Purpose  : 640x480@60 raster counters plus delayed sync/blank/markers.
// Revision : 1.0
// ============================================================================
module vga_timing_gen #(
  parameter int H_ACTIVE        = 640,
  parameter int H_FP            = 16,
  parameter int H_SYNC          = 96,
  parameter int H_BP            = 48,
  parameter int V_ACTIVE        = 480,
  parameter int V_FP            = 10,
  parameter int V_SYNC          = 2,
  parameter int V_BP            = 33,
  parameter int SYNC_ACTIVE_LOW = 1,
  parameter int PIPE_DELAY      = 1
) (
  input  logic       vga_clk,
  input  logic       reset,
  input  logic       clk_en,
  output logic [9:0] hcount,
  output logic [9:0] vcount,
  output logic       vga_hs,
  output logic       vga_vs,
  output logic       vga_blank_n,
  output logic       frame_start,
  output logic       line_start
);

  localparam int         c_h_total  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int         c_v_total  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [9:0] c_h_max    = 10'(c_h_total - 1);
  localparam logic [9:0] c_v_max    = 10'(c_v_total - 1);
  localparam logic [9:0] c_h_active = 10'(H_ACTIVE);
  localparam logic [9:0] c_v_active = 10'(V_ACTIVE);
  localparam logic [9:0] c_hs_first = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] c_hs_last  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] c_vs_first = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] c_vs_last  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic       c_sync_inv = (SYNC_ACTIVE_LOW != 0);

  // Flag vector layout: {hs, vs, active, frame_start, line_start}, all active-high.
  localparam int c_fw = 5;

  logic [9:0]                       r_h_cnt;
  logic [9:0]                       r_v_cnt;
  logic [PIPE_DELAY-1:0][c_fw-1:0]  r_pipe;
  logic [c_fw-1:0]                  w_flags;
  logic [c_fw-1:0]                  w_out;

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (clk_en) begin
      if (r_h_cnt == c_h_max) begin
        r_h_cnt <= '0;
        r_v_cnt <= (r_v_cnt == c_v_max) ? 10'd0 : r_v_cnt + 10'd1;
      end else begin
        r_h_cnt <= r_h_cnt + 10'd1;
      end
    end
  end

  always_comb begin
    w_flags    = '0;
    w_flags[4] = (r_h_cnt >= c_hs_first) && (r_h_cnt <= c_hs_last);
    w_flags[3] = (r_v_cnt >= c_vs_first) && (r_v_cnt <= c_vs_last);
    w_flags[2] = (r_h_cnt < c_h_active) && (r_v_cnt < c_v_active);
    w_flags[1] = (r_h_cnt == 10'd0) && (r_v_cnt == 10'd0);
    w_flags[0] = (r_h_cnt == 10'd0);
  end

  // Delay line keeps flags aligned with the renderer's registered ROM data.
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      r_pipe <= '0;
    end else if (clk_en) begin
      r_pipe[0] <= w_flags;
      for (int i = 1; i < PIPE_DELAY; i++) begin
        r_pipe[i] <= r_pipe[i-1];
      end
    end
  end

  assign w_out       = r_pipe[PIPE_DELAY-1];
  assign hcount      = r_h_cnt;
  assign vcount      = r_v_cnt;
  assign vga_hs      = w_out[4] ^ c_sync_inv;
  assign vga_vs      = w_out[3] ^ c_sync_inv;
  assign vga_blank_n = w_out[2];
  assign frame_start = w_out[1];
  assign line_start  = w_out[0];

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_timing_gen
// Purpose  : Scoreboard bench for vga_timing_gen on a shrunken raster.
// Revision : 1.0
// ============================================================================
module tb_vga_timing_gen;

  localparam int HA = 16, HF = 4, HS = 6, HB = 6;
  localparam int VA = 12, VF = 2, VS = 2, VB = 4;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;
  localparam int DA = 1;
  localparam int DB = 3;
  // {hs_pin, vs_pin, blank_n, frame_start, line_start} when idle/reset
  localparam logic [4:0] IDLE = 5'b11000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clk_en = 1'b0;

  logic [9:0] hc_a, vc_a, hc_b, vc_b;
  logic hs_a, vs_a, bl_a, fs_a, ls_a;
  logic hs_b, vs_b, bl_b, fs_b, ls_b;

  always #5 clk = ~clk;

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_ACTIVE_LOW(1), .PIPE_DELAY(DA)
  ) u_dut_a (
    .vga_clk(clk), .reset(rst), .clk_en(clk_en),
    .hcount(hc_a), .vcount(vc_a), .vga_hs(hs_a), .vga_vs(vs_a),
    .vga_blank_n(bl_a), .frame_start(fs_a), .line_start(ls_a)
  );

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_ACTIVE_LOW(1), .PIPE_DELAY(DB)
  ) u_dut_b (
    .vga_clk(clk), .reset(rst), .clk_en(clk_en),
    .hcount(hc_b), .vcount(vc_b), .vga_hs(hs_b), .vga_vs(vs_b),
    .vga_blank_n(bl_b), .frame_start(fs_b), .line_start(ls_b)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference raster position and per-instance scoreboards of expected flags.
  int         mh, mv;
  logic [4:0] qa[$];
  logic [4:0] qb[$];
  logic [4:0] exp_a, exp_b;
  logic       last_en;

  function automatic logic [4:0] ref_flags(input int h, input int v);
    logic hs_on, vs_on, act;
    hs_on = (h >= HA + HF) && (h < HA + HF + HS);
    vs_on = (v >= VA + VF) && (v < VA + VF + VS);
    act   = (h < HA) && (v < VA);
    return {!hs_on, !vs_on, act, (h == 0) && (v == 0), h == 0};
  endfunction

  task automatic model_reset();
    mh = 0;
    mv = 0;
    qa.delete();
    qb.delete();
    for (int i = 0; i < DA - 1; i++) qa.push_back(IDLE);
    for (int i = 0; i < DB - 1; i++) qb.push_back(IDLE);
    exp_a = IDLE;
    exp_b = IDLE;
  endtask

  task automatic tick();
    @(posedge clk);
    last_en = clk_en && !rst;
    if (rst) begin
      model_reset();
    end else if (clk_en) begin
      qa.push_back(ref_flags(mh, mv));
      qb.push_back(ref_flags(mh, mv));
      exp_a = qa.pop_front();
      exp_b = qb.pop_front();
      if (mh == HT - 1) begin
        mh = 0;
        mv = (mv == VT - 1) ? 0 : mv + 1;
      end else begin
        mh = mh + 1;
      end
    end
    #1;
    check("outs_a", {hc_a, vc_a, hs_a, vs_a, bl_a, fs_a, ls_a}, {10'(mh), 10'(mv), exp_a});
    check("outs_b", {hc_b, vc_b, hs_b, vs_b, bl_b, fs_b, ls_b}, {10'(mh), 10'(mv), exp_b});
  endtask

  int   fs1, fs2, vs_fall, hs_fall, hs_low, vs_low, bl_high, ls_high;
  int   r1, r2, ls_rises, hs_en_low;
  logic pf, pv, ph, pl;

  initial begin
    model_reset();
    #1;
    check("reset_a", {hc_a, vc_a, hs_a, vs_a, bl_a, fs_a, ls_a}, {20'd0, IDLE});
    check("reset_b", {hc_b, vc_b, hs_b, vs_b, bl_b, fs_b, ls_b}, {20'd0, IDLE});
    tick();
    tick();
    rst    = 1'b0;
    clk_en = 1'b1;

    // Two full frames with continuous enable.
    fs1 = -1; fs2 = -1; vs_fall = -1; hs_fall = -1;
    hs_low = 0; vs_low = 0; bl_high = 0; ls_high = 0;
    pf = 1'b0; pv = 1'b1; ph = 1'b1;
    for (int k = 1; k <= 2 * FRAME; k++) begin
      tick();
      if (!hs_a) hs_low++;
      if (!vs_a) vs_low++;
      if (bl_a) bl_high++;
      if (ls_a) ls_high++;
      if (fs_a && !pf) begin
        if (fs1 < 0) fs1 = k;
        else if (fs2 < 0) fs2 = k;
      end
      if (!vs_a && pv && vs_fall < 0) vs_fall = k;
      if (!hs_a && ph && hs_fall < 0) hs_fall = k;
      pf = fs_a; pv = vs_a; ph = hs_a;
    end
    check("first_fs_edge", fs1, 1);
    check("frame_period", fs2 - fs1, FRAME);
    check("hs_first_fall", hs_fall, HA + HF + 1);
    check("vs_first_fall", vs_fall, (VA + VF) * HT + 1);
    check("hs_low_cycles", hs_low, 2 * VT * HS);
    check("vs_low_cycles", vs_low, 2 * VS * HT);
    check("blank_high_cycles", bl_high, 2 * HA * VA);
    check("line_start_cycles", ls_high, 2 * VT);

    // Alternating enable: periods double, per-frame counts unchanged.
    r1 = -1; r2 = -1; ls_rises = 0; hs_en_low = 0;
    pf = fs_a; pl = ls_a;
    for (int i = 1; i <= 4 * FRAME + 8; i++) begin
      clk_en = ~clk_en;
      tick();
      if (fs_a && !pf) begin
        if (r1 < 0) r1 = i;
        else if (r2 < 0) r2 = i;
      end
      if (r1 >= 0 && r2 < 0) begin
        if (ls_a && !pl) ls_rises++;
        if (last_en && !hs_a) hs_en_low++;
      end
      pf = fs_a; pl = ls_a;
    end
    check("gated_frame_period", r2 - r1, 2 * FRAME);
    check("gated_lines", ls_rises, VT);
    check("gated_hs_low", hs_en_low, VT * HS);

    // Mid-frame asynchronous reset.
    clk_en = 1'b1;
    for (int i = 0; i < 2 * FRAME && !(mh == 10 && mv == 7); i++) tick();
    check("pre_reset_pos", {hc_a, vc_a}, {10'd10, 10'd7});
    rst = 1'b1;
    #1;
    check("async_reset_a", {hc_a, vc_a, hs_a, vs_a, bl_a, fs_a, ls_a}, {20'd0, IDLE});
    check("async_reset_b", {hc_b, vc_b, hs_b, vs_b, bl_b, fs_b, ls_b}, {20'd0, IDLE});
    model_reset();
    tick();
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("fs_after_reset", {fs_a, ls_a, bl_a}, 3'b111);
    check("count_after_reset", {hc_a, vc_a}, {10'd1, 10'd0});
    for (int i = 0; i < 4 * HT; i++) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
